// File: rtl/vidgen_pkg.sv
// Shared raster constants, noise LFSR taps and video-mode type for the
// noise video generator.
package vidgen_pkg;

    localparam logic [8:0]  H_TOTAL       = 9'd400;
    localparam logic [8:0]  H_ACTIVE      = 9'd320;
    localparam logic [8:0]  HS_START      = 9'd336;
    localparam logic [8:0]  HS_END        = 9'd367;

    localparam logic [8:0]  NTSC_V_TOTAL  = 9'd262;
    localparam logic [8:0]  NTSC_V_ACTIVE = 9'd240;
    localparam logic [8:0]  NTSC_VS_START = 9'd245;
    localparam logic [8:0]  NTSC_VS_END   = 9'd247;

    localparam logic [8:0]  PAL_V_TOTAL   = 9'd312;
    localparam logic [8:0]  PAL_V_ACTIVE  = 9'd288;
    localparam logic [8:0]  PAL_VS_START  = 9'd295;
    localparam logic [8:0]  PAL_VS_END    = 9'd297;

    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;

    typedef enum logic {
        VM_NTSC = 1'b0,
        VM_PAL  = 1'b1
    } vmode_t;

    function automatic logic [8:0] v_total(input vmode_t mode);
        case (mode)
            VM_PAL:  return PAL_V_TOTAL;
            default: return NTSC_V_TOTAL;
        endcase
    endfunction

    function automatic logic [8:0] v_active(input vmode_t mode);
        case (mode)
            VM_PAL:  return PAL_V_ACTIVE;
            default: return NTSC_V_ACTIVE;
        endcase
    endfunction

    function automatic logic [8:0] vs_start(input vmode_t mode);
        case (mode)
            VM_PAL:  return PAL_VS_START;
            default: return NTSC_VS_START;
        endcase
    endfunction

    function automatic logic [8:0] vs_end(input vmode_t mode);
        case (mode)
            VM_PAL:  return PAL_VS_END;
            default: return NTSC_VS_END;
        endcase
    endfunction

    // Right-shifting Galois step: feedback taps are applied when bit 0 falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] q);
        if (q[0]) begin
            return (q >> 1) ^ LFSR_TAPS;
        end else begin
            return q >> 1;
        end
    endfunction

endpackage

// File: rtl/vidgen_lfsr.sv
// 32-bit Galois noise LFSR; a zero seed is replaced by 1 so the register
// can never start in the all-zero lock-up state.
module vidgen_lfsr
    import vidgen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] q
);

    logic [31:0] load_s;

    // Reload value, with the zero seed mapped to 1.
    always_comb begin
        if (seed == 32'h0000_0000) begin
            load_s = 32'h0000_0001;
        end else begin
            load_s = seed;
        end
    end

    // State register: reload on reset, advance one step when requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= load_s;
        end else if (step) begin
            q <= lfsr_next(q);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/noise_video_gen.sv
// Noise test-pattern raster generator (NTSC/PAL, optional line doubling).
// Define NOISE_VIDEO_GEN_BORDER_EN to draw a white frame around the active area.
module noise_video_gen
    import vidgen_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pal,
    input  logic       scandouble,
    output logic       ce_pix,
    output logic       HBlank,
    output logic       HSync,
    output logic       VBlank,
    output logic       VSync,
    output logic [7:0] video
);

    logic [1:0]  div_r;
    logic        sd_r;
    logic        ce_r;
    logic [8:0]  hcnt_r;
    logic [8:0]  vcnt_r;
    logic        rep_r;
    vmode_t      mode_r;
    logic        hb_r, hs_r, vb_r, vs_r;
    logic [7:0]  video_r;

    logic        div_wrap_s;
    logic [8:0]  hcnt_nxt_s;
    logic [8:0]  vcnt_nxt_s;
    logic        rep_nxt_s;
    vmode_t      mode_nxt_s;
    logic        hb_s, hs_s, vb_s, vs_s, active_s;
    logic [7:0]  pix_s;
    logic        lfsr_step_s;
    logic [31:0] lfsr_q_s;
    logic [7:0]  noise_s;
    logic [23:0] lfsr_hi_unused_s;
`ifdef NOISE_VIDEO_GEN_BORDER_EN
    logic        border_s;
`endif

    // Divider wrap; the line-double choice only switches at a wrap so ce stays clean.
    always_comb begin
        if (sd_r) begin
            div_wrap_s = div_r[0];
        end else begin
            div_wrap_s = (div_r == 2'd3);
        end
    end

    // Raster counter next state; vcnt steps on every second wrap when line-doubling.
    always_comb begin
        hcnt_nxt_s = hcnt_r;
        vcnt_nxt_s = vcnt_r;
        rep_nxt_s  = rep_r;
        mode_nxt_s = mode_r;
        if (ce_r) begin
            if (hcnt_r == H_TOTAL - 9'd1) begin
                hcnt_nxt_s = 9'd0;
                rep_nxt_s  = sd_r ? ~rep_r : 1'b0;
                if (!sd_r || rep_r) begin
                    if (vcnt_r == v_total(mode_r) - 9'd1) begin
                        vcnt_nxt_s = 9'd0;
                        mode_nxt_s = vmode_t'(pal);
                    end else begin
                        vcnt_nxt_s = vcnt_r + 9'd1;
                    end
                end else begin
                    vcnt_nxt_s = vcnt_r;
                end
            end else begin
                hcnt_nxt_s = hcnt_r + 9'd1;
            end
        end else begin
            hcnt_nxt_s = hcnt_r;
        end
    end

    // Timing decode and pixel value for the current raster position.
    always_comb begin
        hb_s     = (hcnt_r >= H_ACTIVE);
        hs_s     = (hcnt_r >= HS_START) && (hcnt_r <= HS_END);
        vb_s     = (vcnt_r >= v_active(mode_r));
        vs_s     = (vcnt_r >= vs_start(mode_r)) && (vcnt_r <= vs_end(mode_r));
        active_s = !hb_s && !vb_s;
`ifdef NOISE_VIDEO_GEN_BORDER_EN
        border_s = (hcnt_r == 9'd0) || (hcnt_r == H_ACTIVE - 9'd1) ||
                   (vcnt_r == 9'd0) || (vcnt_r == v_active(mode_r) - 9'd1);
        if (!active_s) begin
            pix_s = 8'd0;
        end else if (border_s) begin
            pix_s = 8'hFF;
        end else begin
            pix_s = noise_s;
        end
`else
        if (active_s) begin
            pix_s = noise_s;
        end else begin
            pix_s = 8'd0;
        end
`endif
    end

    assign lfsr_step_s      = ce_r && active_s;
    assign noise_s          = lfsr_q_s[7:0];
    assign lfsr_hi_unused_s = lfsr_q_s[31:8];

    vidgen_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step_s),
        .seed  (LFSR_SEED),
        .q     (lfsr_q_s)
    );

    // Pixel-enable divider and raster counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r  <= 2'd0;
            sd_r   <= scandouble;
            ce_r   <= 1'b0;
            hcnt_r <= 9'd0;
            vcnt_r <= 9'd0;
            rep_r  <= 1'b0;
            mode_r <= vmode_t'(pal);
        end else begin
            if (div_wrap_s) begin
                div_r <= 2'd0;
                sd_r  <= scandouble;
            end else begin
                div_r <= div_r + 2'd1;
                sd_r  <= sd_r;
            end
            ce_r   <= div_wrap_s;
            hcnt_r <= hcnt_nxt_s;
            vcnt_r <= vcnt_nxt_s;
            rep_r  <= rep_nxt_s;
            mode_r <= mode_nxt_s;
        end
    end

    // Output registers: sync flags and luma all update on the same pixel edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hb_r    <= 1'b0;
            hs_r    <= 1'b0;
            vb_r    <= 1'b0;
            vs_r    <= 1'b0;
            video_r <= 8'd0;
        end else if (ce_r) begin
            hb_r    <= hb_s;
            hs_r    <= hs_s;
            vb_r    <= vb_s;
            vs_r    <= vs_s;
            video_r <= pix_s;
        end else begin
            hb_r    <= hb_r;
            hs_r    <= hs_r;
            vb_r    <= vb_r;
            vs_r    <= vs_r;
            video_r <= video_r;
        end
    end

    assign ce_pix = ce_r;
    assign HBlank = hb_r;
    assign HSync  = hs_r;
    assign VBlank = vb_r;
    assign VSync  = vs_r;
    assign video  = video_r;

endmodule

// File: tb/tb_noise_video_gen.sv
// Scoreboard bench for noise_video_gen: stimulus pushes expected pixels,
// a negedge monitor pops and compares on each pixel output.
`timescale 1ns/1ps
module tb_noise_video_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pal = 1'b0;
    logic       scandouble = 1'b0;
    logic       ce_pix, HBlank, HSync, VBlank, VSync;
    logic [7:0] video;

    noise_video_gen #(.LFSR_SEED(32'h0000_0001)) dut (
        .clk        (clk),
        .reset      (reset),
        .pal        (pal),
        .scandouble (scandouble),
        .ce_pix     (ce_pix),
        .HBlank     (HBlank),
        .HSync      (HSync),
        .VBlank     (VBlank),
        .VSync      (VSync),
        .video      (video)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] out;   // {hb, hs, vb, vs, video}
        int          h;
        int          v;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          exp_period = 4;

    int          m_h, m_v;
    bit          m_mode, m_rep, m_sd;
    logic [31:0] m_lfsr;

    function automatic logic [31:0] gal(input logic [31:0] x);
        logic [31:0] r;
        r = x >> 1;
        if (x[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    // Expected pixels from an independent raster/noise model.
    task automatic push_pixels(input int n);
        exp_t e;
        int   vact, vtot, vs0;
        bit   hb, hs, vb, vs, act;
        logic [7:0] pix;
        for (int i = 0; i < n; i++) begin
            vact = m_mode ? 288 : 240;
            vtot = m_mode ? 312 : 262;
            vs0  = m_mode ? 295 : 245;
            hb   = (m_h >= 320);
            hs   = (m_h >= 336) && (m_h <= 367);
            vb   = (m_v >= vact);
            vs   = (m_v >= vs0) && (m_v <= vs0 + 2);
            act  = !hb && !vb;
            pix  = act ? m_lfsr[7:0] : 8'h00;
`ifdef NOISE_VIDEO_GEN_BORDER_EN
            if (act && (m_h == 0 || m_h == 319 || m_v == 0 || m_v == vact - 1)) pix = 8'hFF;
`endif
            e.out = {hb, hs, vb, vs, pix};
            e.h   = m_h;
            e.v   = m_v;
            sb_q.push_back(e);
            if (act) m_lfsr = gal(m_lfsr);
            m_h++;
            if (m_h == 400) begin
                m_h = 0;
                if (!m_sd || m_rep) begin
                    if (m_v == vtot - 1) begin
                        m_v    = 0;
                        m_mode = pal;
                    end else begin
                        m_v++;
                    end
                end
                m_rep = m_sd ? !m_rep : 1'b0;
            end
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_%s: %0d pixels never emitted, required 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Places the raster on line v before the next pixel is computed.
    task automatic jump(input int v);
        force dut.vcnt_r = 9'(v);
        @(posedge clk);
        #1;
        release dut.vcnt_r;
        m_v = v;
    endtask

    task automatic start(input bit p, input bit sd, input int v0);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        pal        = p;
        scandouble = sd;
        repeat (3) @(posedge clk);
        #1;
        sb_q.delete();
        m_h = 0; m_v = 0; m_mode = p; m_rep = 1'b0; m_sd = sd;
        m_lfsr     = 32'h0000_0001;
        exp_period = sd ? 2 : 4;
        reset      = 1'b0;
        if (v0 >= 0) jump(v0);
    endtask

    // Monitor: reset state, pixel scoreboard and ce_pix spacing.
    logic        rst_prev = 1'b0;
    logic        ce_prev = 1'b0;
    int          clk_cnt = 0;
    logic [11:0] act_v;
    exp_t        got_e;

    always @(negedge clk) begin
        act_v = {HBlank, HSync, VBlank, VSync, video};
        if (rst_prev) begin
            n_vec++;
            if (ce_pix !== 1'b0 || act_v !== 12'h000) begin
                n_err++;
                $display("FAIL reset_state: got ce=%b out=%h, required ce=0 out=000", ce_pix, act_v);
            end
            clk_cnt = 0;
        end else begin
            if (ce_prev && sb_q.size() != 0) begin
                got_e = sb_q.pop_front();
                n_vec++;
                if (act_v !== got_e.out) begin
                    n_err++;
                    $display("FAIL pixel h=%0d v=%0d: got hb/hs/vb/vs/video=%h, required %h",
                             got_e.h, got_e.v, act_v, got_e.out);
                end
            end
            clk_cnt++;
            if (ce_pix) begin
                n_vec++;
                if (clk_cnt != exp_period) begin
                    n_err++;
                    $display("FAIL ce_period: got %0d clks, required %0d", clk_cnt, exp_period);
                end
                clk_cnt = 0;
            end
        end
        rst_prev = reset;
        ce_prev  = ce_pix;
    end

    initial begin
        // NTSC, no doubling: first line, then the vertical boundaries.
        start(1'b0, 1'b0, -1);
        push_pixels(400);  drain("ntsc_line0");
        jump(239); push_pixels(800); drain("ntsc_vblank");
        jump(244); push_pixels(800); drain("ntsc_vs_start");
        jump(247); push_pixels(800); drain("ntsc_vs_end");
        jump(261); push_pixels(800); drain("ntsc_wrap");

        // PAL, line doubled: each line repeats, vcnt steps every second wrap.
        start(1'b1, 1'b1, -1);
        push_pixels(800);  drain("pal_sd_line0");
        jump(287); push_pixels(1600); drain("pal_vblank");
        jump(294); push_pixels(1600); drain("pal_vs_start");
        jump(297); push_pixels(1600); drain("pal_vs_end");
        jump(311); push_pixels(1600); drain("pal_wrap");

        // Mode switched mid-frame: old total holds until the frame wraps.
        start(1'b0, 1'b0, 100);
        push_pixels(200);  drain("switch_pre");
        pal = 1'b1;
        push_pixels(200);  drain("switch_post");
        jump(261); push_pixels(800); drain("switch_old_total");
        jump(287); push_pixels(800); drain("switch_new_vblank");
        jump(311); push_pixels(800); drain("switch_new_total");

        // Reset mid-frame at hcnt=200 vcnt=50, then replay the power-up sequence.
        start(1'b0, 1'b0, 50);
        push_pixels(200);  drain("midreset_pre");
        start(1'b0, 1'b0, -1);
        push_pixels(408);  drain("midreset_post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
